// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM activation feeder: FSM encoding and
// counter sizing helper.
package gemm_pkg;

   typedef enum logic [1:0] {
      FEED_IDLE  = 2'b00,
      FEED_RUN   = 2'b01,
      FEED_DRAIN = 2'b10
   } feed_state_e;

   // Drain counter width for a given array size; never narrower than 1 bit.
   function automatic int unsigned drain_cnt_width(input int unsigned array_size);
      return (array_size <= 1) ? 1 : $clog2(array_size);
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Data+valid shift chain of DEPTH register stages; DEPTH=0 is a wire.
module skew_delay_line #(
   parameter int unsigned DEPTH      = 1,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;
         assign out_data  = in_data;
         assign out_valid = in_valid;
      end else begin : g_chain
         logic [DATA_WIDTH-1:0] data_q  [DEPTH];
         logic                  valid_q [DEPTH];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  data_q[i]  <= '0;
                  valid_q[i] <= 1'b0;
               end
            end else begin
               data_q[0]  <= in_data;
               valid_q[0] <= in_valid;
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  data_q[i]  <= data_q[i-1];
                  valid_q[i] <= valid_q[i-1];
               end
            end
         end

         assign out_data  = data_q[DEPTH-1];
         assign out_valid = valid_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/gemm_act_skew_feeder.sv
// Issues activation-buffer reads while run_i is high, skews each returned
// row vector diagonally onto the systolic array west edge, then drains.
module gemm_act_skew_feeder
   import gemm_pkg::*;
#(
   parameter int unsigned ARRAY_SIZE = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             run_i,
   input  logic                             done_i,
   input  logic [ADDR_WIDTH-1:0]            base_addr_i,
   output logic                             rd_en_o,
   output logic [ADDR_WIDTH-1:0]            rd_addr_o,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] rd_data_i,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] array_data_o,
   output logic [ARRAY_SIZE-1:0]            array_valid_o,
   output logic                             done_o,
   output logic                             ovr_err_o
);

   localparam int unsigned     CNT_W      = drain_cnt_width(ARRAY_SIZE);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARRAY_SIZE - 1);

   feed_state_e                     state_q, state_d;
   logic [ADDR_WIDTH-1:0]           offset_q;
   logic [CNT_W-1:0]                drain_cnt_q;
   logic                            rd_vld_q;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] s0_data_q;
   logic                            s0_valid_q;
   logic                            ovr_err_q;
   logic                            rd_en;
   logic                            drain_done;

   always_comb begin
      state_d    = state_q;
      rd_en      = 1'b0;
      drain_done = 1'b0;
      unique case (state_q)
         FEED_IDLE: begin
            rd_en = run_i;
            if (run_i) state_d = FEED_RUN;
         end
         FEED_RUN: begin
            rd_en = run_i;
            if (done_i) state_d = FEED_DRAIN;
         end
         FEED_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               drain_done = 1'b1;
               state_d    = FEED_IDLE;
            end
         end
         default: state_d = FEED_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FEED_IDLE;
         offset_q    <= '0;
         drain_cnt_q <= '0;
         rd_vld_q    <= 1'b0;
         s0_data_q   <= '0;
         s0_valid_q  <= 1'b0;
         ovr_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;

         if (drain_done) begin
            offset_q <= '0;
         end else if (rd_en) begin
            offset_q <= offset_q + ADDR_WIDTH'(1);
         end

         if (state_q == FEED_RUN && done_i) begin
            drain_cnt_q <= '0;
         end else if (state_q == FEED_DRAIN) begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
         end

         rd_vld_q   <= rd_en;
         s0_valid_q <= rd_vld_q;
         s0_data_q  <= rd_vld_q ? rd_data_i : '0;

         if (run_i && state_q == FEED_DRAIN) ovr_err_q <= 1'b1;
      end
   end

   // Outputs held low while reset is asserted, even before the first reset edge.
   assign rd_en_o   = rd_en && rst_n;
   assign rd_addr_o = base_addr_i + offset_q;
   assign done_o    = drain_done && rst_n;
   assign ovr_err_o = ovr_err_q;

   for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
      logic [DATA_WIDTH-1:0] row_data;
      logic                  row_valid;

      skew_delay_line #(
         .DEPTH      (r),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_skew (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_data   (s0_data_q[r*DATA_WIDTH +: DATA_WIDTH]),
         .in_valid  (s0_valid_q),
         .out_data  (row_data),
         .out_valid (row_valid)
      );

      assign array_valid_o[r] = row_valid && rst_n;
      assign array_data_o[r*DATA_WIDTH +: DATA_WIDTH] = array_valid_o[r] ? row_data : '0;
   end

endmodule

// File: doc/gemm_act_skew_feeder.md
Name: gemm_act_skew_feeder

Overview:
Downstream consumer of the GEMM run/done counter. While the counter's run pulse is high, it issues one activation-buffer read per cycle. It then skews each returned ARRAY_SIZE-wide row vector diagonally, delaying row r by r cycles, and drives the systolic array's west edge. After the counter's done pulse it drains the skew pipeline and pulses done_o when the last element has entered the array.

Parameters:
ARRAY_SIZE, 4, systolic array rows; also the expected run length per tile
DATA_WIDTH, 8, bits per activation element
ADDR_WIDTH, 6, activation buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
run_i  in  1  counter run indication; one read per high cycle
done_i  in  1  counter done pulse, one cycle, the cycle after the last run_i
base_addr_i  in  ADDR_WIDTH  tile base address; held stable from first run_i through done_o
rd_en_o  out  1  buffer read enable
rd_addr_o  out  ADDR_WIDTH  buffer read address
rd_data_i  in  ARRAY_SIZE*DATA_WIDTH  buffer data, valid exactly 1 cycle after rd_en_o; row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
array_data_o  out  ARRAY_SIZE*DATA_WIDTH  skewed data to array rows, same packing
array_valid_o  out  ARRAY_SIZE  per-row valid
done_o  out  1  one-cycle pulse: final skewed element presented
ovr_err_o  out  1  sticky: run_i seen during DRAIN

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, offset=0, all delay-line stages and valids cleared, ovr_err_o=0.
  - Outputs during and after reset: rd_en_o=0, array_valid_o=0, array_data_o=0, done_o=0.
  - Reset asserted mid-tile discards all in-flight data. No done_o is produced for that tile.
- States (encoding in package): IDLE, FEED, DRAIN.
  - IDLE: run_i=1 -> FEED. The read is issued in this same cycle.
  - FEED: done_i=1 -> DRAIN with drain_cnt=0.
  - DRAIN: drain_cnt increments each cycle. At drain_cnt==ARRAY_SIZE-1 done_o=1 and next state is IDLE.
- Read side:
  - rd_en_o = run_i && state!=DRAIN (combinational).
  - rd_addr_o = base_addr_i + offset, ADDR_WIDTH arithmetic, wrapping mod 2^ADDR_WIDTH.
  - offset increments on every rd_en_o cycle and is cleared on entry to IDLE.
- Capture: rd_vld = rd_en_o registered 1 cycle. rd_data_i is registered into stage 0 of every row when rd_vld=1.
- Skew: row r is passed through r further register stages; each valid bit travels with its data.
  - Latency from rd_en_o to array_valid_o[r]: 2+r cycles.
  - array_data_o row r is forced to 0 whenever array_valid_o[r]=0.
- Drain timing: last read at cycle t, done_i at t+1, DRAIN spans t+2..t+1+ARRAY_SIZE, done_o at t+1+ARRAY_SIZE. This coincides with the last array_valid_o[ARRAY_SIZE-1]. ARRAY_SIZE=1 gives a 1-cycle DRAIN with done_o at t+2.
- Simultaneous/illegal events:
  - done_i while IDLE: ignored.
  - run_i during DRAIN: no read, ovr_err_o=1 until reset, drain continues normally.
  - run_i and done_i both high in FEED: done_i wins. The read is still issued; its data is drained.
- Run length is not restricted. Tiles longer or shorter than ARRAY_SIZE stream correctly; the skew is per element.

Decomposition:
- Shared package gemm_pkg holds:
  - feeder state localparams FEED_IDLE=2'b00, FEED_RUN=2'b01, FEED_DRAIN=2'b10
  - a helper constant for the drain counter width, $clog2 of ARRAY_SIZE (minimum 1)
- One sub-module, skew_delay_line: parameters DEPTH and DATA_WIDTH; carries a data+valid shift chain, zero-depth pass-through when DEPTH=0. The top instantiates one per row via generate with DEPTH=r.

Test Plan:
- Reset mid-tile: rst_n low for 1 cycle at offset 2 -> next cycle all outputs 0, state IDLE, no done_o; a following tile runs normally.
- Single tile (ARRAY_SIZE=4, base_addr_i=0x10, buffer returns element {addr[3:0],row[3:0]}, run_i high cycles 0-3, done_i cycle 4):
  - rd_addr_o is 0x10,0x11,0x12,0x13 in cycles 0-3.
  - Row 0 valid cycles 2-5 with 0x00,0x10,0x20,0x30; row 3 valid cycles 5-8 with 0x03,0x13,0x23,0x33.
  - done_o only in cycle 8.
- Address wrap: base_addr_i=0x3E, run 4 cycles -> rd_addr_o 0x3E,0x3F,0x00,0x01.
- Back-to-back tiles: second run_i starts the cycle after done_o -> no ovr_err_o; outputs are the same sequence shifted by 9 cycles.
- Early restart: run_i=1 at the second DRAIN cycle -> rd_en_o=0, ovr_err_o=1 sticky; done_o still at its scheduled cycle.
- ARRAY_SIZE=1 build: 3-cycle run -> array_valid_o high 3 cycles starting 2 after the first read; done_o 1 cycle after done_i.
